// File: rtl/colors_to_bytes.sv
`default_nettype none
// ============================================================================
// Module   : colors_to_bytes
// Purpose  : Packs 12-bit colors into a byte stream through a 6-nibble queue,
//            with a flush that zero-pads a trailing half byte.
// Revision : 1.0 - initial release
// ============================================================================
module colors_to_bytes (
    input  logic        clk,
    input  logic        rst,
    input  logic        inclk,
    input  logic [11:0] in,
    input  logic        flush,
    output logic        inready,
    output logic        outclk,
    output logic [7:0]  out,
    output logic        overflow,
    output logic        busy
);

    localparam int COLOR_LEN = 12;
    localparam int BYTE_LEN  = 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [23:0]             r_q;          // nibble i lives at [4*i +: 4], head is nibble 0
    logic [23:0]             w_q_next;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_next;
    logic [2:0]              w_base;
    logic                    r_outclk;
    logic [BYTE_LEN-1:0]     r_out;
    logic                    r_overflow;
    logic                    r_busy;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_deq;
    logic                    w_tail;
    logic                    w_emit;
    logic [BYTE_LEN-1:0]     w_byte;
    logic [COLOR_LEN-1:0]    w_enq;

    assign w_ready  = (r_cnt <= 3'd3) && (r_state == S_IDLE);
    assign w_accept = inclk && w_ready;
    assign w_drop   = inclk && !w_ready;
    assign w_deq    = (r_cnt >= 3'd2);
    assign w_tail   = (r_state == S_FLUSH) && (r_cnt == 3'd1);
    assign w_emit   = w_deq || w_tail;
    assign w_byte   = w_deq ? {r_q[3:0], r_q[7:4]} : {r_q[3:0], 4'h0};
    // Reversed so the color's top nibble lands nearest the queue head.
    assign w_enq    = {in[3:0], in[7:4], in[11:8]};

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_base       = r_cnt;
        if (w_deq) begin
            w_q_next = r_q >> 8;
            w_base   = r_cnt - 3'd2;
        end else if (w_tail) begin
            w_q_next = r_q >> 4;
            w_base   = 3'd0;
        end
        if (w_accept) begin
            w_q_next[{w_base, 2'b00} +: 12] = w_enq;
        end
        w_cnt_next = w_base + (w_accept ? 3'd3 : 3'd0);

        case (r_state)
            S_IDLE:  if (flush) w_state_next = S_FLUSH;
            S_FLUSH: if (r_cnt <= 3'd1) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_cnt      <= 3'd0;
            r_outclk   <= 1'b0;
            r_out      <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_q      <= w_q_next;
            r_cnt    <= w_cnt_next;
            r_outclk <= w_emit;
            if (w_emit) r_out <= w_byte;
            if (w_drop) r_overflow <= 1'b1;
            r_busy   <= (w_cnt_next != 3'd0) || (w_state_next == S_FLUSH);
        end
    end

    assign inready  = w_ready;
    assign outclk   = r_outclk;
    assign out      = r_out;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_colors_to_bytes.sv
`default_nettype none
// ============================================================================
// Module   : tb_colors_to_bytes
// Purpose  : Self-checking bench for colors_to_bytes; directed scenarios plus
//            random traffic against a nibble-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_colors_to_bytes;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inclk = 1'b0;
    logic [11:0] in = 12'h0;
    logic        flush = 1'b0;
    logic        inready, outclk, overflow, busy;
    logic [7:0]  out;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: nibble queue, pending-flush flag, expected registered outputs.
    logic [3:0] mq[$];
    bit         m_fp = 1'b0;
    bit         m_ov = 1'b0;
    bit         m_outclk = 1'b0;
    logic [7:0] m_out = 8'h00;
    bit         m_busy = 1'b0;

    colors_to_bytes dut (
        .clk(clk), .rst(rst), .inclk(inclk), .in(in), .flush(flush),
        .inready(inready), .outclk(outclk), .out(out),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return (mq.size() <= 3) && !m_fp;
    endfunction

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic tick(input bit ic, input logic [11:0] d, input bit fl, input bit r);
        int  n0;
        bit  rdy;
        logic [3:0] a, b;
        inclk = ic; in = d; flush = fl; rst = r;
        if (r) begin
            mq.delete(); m_fp = 0; m_ov = 0; m_outclk = 0; m_out = 8'h00;
        end else begin
            n0 = mq.size();
            rdy = m_ready();
            m_outclk = 0;
            if (n0 >= 2) begin
                a = mq.pop_front(); b = mq.pop_front();
                m_out = {a, b}; m_outclk = 1;
            end else if (m_fp && n0 == 1) begin
                a = mq.pop_front();
                m_out = {a, 4'h0}; m_outclk = 1;
            end
            if (ic && rdy) begin
                mq.push_back(d[11:8]); mq.push_back(d[7:4]); mq.push_back(d[3:0]);
            end else if (ic) begin
                m_ov = 1;
            end
            if (m_fp) begin
                if (n0 <= 1) m_fp = 0;
            end else if (fl) begin
                m_fp = 1;
            end
        end
        m_busy = (mq.size() != 0) || m_fp;
        @(posedge clk); #1;
        inclk = 0; flush = 0; rst = 0;
    endtask

    task automatic test_reset();
        tick(0, 12'h0, 0, 1);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL reset_outclk got=%b exp=0", outclk); end
        tests_run++; if (out !== 8'h00) begin tests_failed++; $display("FAIL reset_out got=%h exp=00", out); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (inready !== 1'b1) begin tests_failed++; $display("FAIL reset_inready got=%b exp=1", inready); end
    endtask

    task automatic test_pair();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hAB; exp_b[1] = 8'hCD; exp_b[2] = 8'hEF;
        tick(1, 12'hABC, 0, 0);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL pair_early_outclk got=%b exp=0", outclk); end
        tick(1, 12'hDEF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (outclk !== 1'b1 || out !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL pair_byte%0d got outclk=%b out=%h exp outclk=1 out=%h", i, outclk, out, exp_b[i]);
            end
            if (i < 2) tick(0, 12'h0, 0, 0);
        end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL pair_busy_after got=%b exp=0", busy); end
        tick(0, 12'h0, 0, 0);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL pair_no_extra got=%b exp=0", outclk); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] colors [4];
        logic [7:0]  exp_b [6];
        logic [7:0]  got[$];
        int idx = 0;
        int rejects = 0;
        colors[0] = 12'hDEA; colors[1] = 12'hDBE; colors[2] = 12'hEFC; colors[3] = 12'hAFE;
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE;
        exp_b[3] = 8'hEF; exp_b[4] = 8'hCA; exp_b[5] = 8'hFE;
        for (int cyc = 0; cyc < 14; cyc++) begin
            bit present = (idx < 4);
            bit rdy = m_ready();
            tests_run++;
            if (inready !== rdy) begin tests_failed++; $display("FAIL b2b_inready cyc=%0d got=%b exp=%b", cyc, inready, rdy); end
            if (present && !rdy) rejects++;
            tick(present, present ? colors[idx] : 12'h0, 0, 0);
            if (present && rdy) idx++;
            if (outclk === 1'b1) got.push_back(out);
            tests_run++;
            if (overflow !== (rejects > 0)) begin tests_failed++; $display("FAIL b2b_overflow cyc=%0d got=%b exp=%b", cyc, overflow, rejects > 0); end
        end
        tests_run++;
        if (got.size() != 6) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
        end
        tests_run++; if (rejects < 1) begin tests_failed++; $display("FAIL b2b_rejects got=%0d exp>=1", rejects); end
    endtask

    task automatic test_reset_mid();
        tick(1, 12'h456, 0, 0);
        tick(0, 12'h0, 0, 1);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL rmid_outclk got=%b exp=0", outclk); end
        tests_run++; if (out !== 8'h00) begin tests_failed++; $display("FAIL rmid_out got=%h exp=00", out); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rmid_overflow got=%b exp=0", overflow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 12'h0, 0, 0);
            tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL rmid_late_outclk%0d got=%b exp=0", i, outclk); end
        end
    endtask

    task automatic test_odd_flush();
        tick(1, 12'h123, 0, 0);
        tick(0, 12'h0, 1, 0);
        tests_run++;
        if (outclk !== 1'b1 || out !== 8'h12) begin tests_failed++; $display("FAIL oflush_b0 got outclk=%b out=%h exp 1/12", outclk, out); end
        tick(0, 12'h0, 0, 0);
        tests_run++;
        if (outclk !== 1'b1 || out !== 8'h30) begin tests_failed++; $display("FAIL oflush_b1 got outclk=%b out=%h exp 1/30", outclk, out); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL oflush_busy got=%b exp=0", busy); end
        tick(0, 12'h0, 0, 0);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL oflush_extra got=%b exp=0", outclk); end
        tests_run++; if (inready !== 1'b1) begin tests_failed++; $display("FAIL oflush_inready got=%b exp=1", inready); end
    endtask

    task automatic test_empty_flush();
        tick(0, 12'h0, 1, 0);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL eflush_outclk0 got=%b exp=0", outclk); end
        tick(0, 12'h0, 0, 0);
        tests_run++; if (outclk !== 1'b0) begin tests_failed++; $display("FAIL eflush_outclk1 got=%b exp=0", outclk); end
        tests_run++; if (inready !== 1'b1) begin tests_failed++; $display("FAIL eflush_inready got=%b exp=1", inready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL eflush_busy got=%b exp=0", busy); end
    endtask

    task automatic test_simultaneous();
        tick(1, 12'h789, 1, 0);
        tests_run++; if (inready !== 1'b0 || outclk !== 1'b0) begin tests_failed++; $display("FAIL simul_c1 got inready=%b outclk=%b exp 0/0", inready, outclk); end
        tick(0, 12'h0, 0, 0);
        tests_run++;
        if (outclk !== 1'b1 || out !== 8'h78 || inready !== 1'b0) begin
            tests_failed++; $display("FAIL simul_b0 got outclk=%b out=%h inready=%b exp 1/78/0", outclk, out, inready);
        end
        tick(0, 12'h0, 0, 0);
        tests_run++; if (outclk !== 1'b1 || out !== 8'h90) begin tests_failed++; $display("FAIL simul_b1 got outclk=%b out=%h exp 1/90", outclk, out); end
        tests_run++; if (inready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL simul_done got inready=%b busy=%b exp 1/0", inready, busy); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit ic = ($urandom_range(0, 99) < 55);
            bit fl = ($urandom_range(0, 99) < 8);
            bit r  = ($urandom_range(0, 199) == 0);
            logic [11:0] d = 12'($urandom);
            bit rdy = m_ready();
            tests_run++;
            if (inready !== rdy) begin tests_failed++; $display("FAIL rand_inready cyc=%0d got=%b exp=%b", cyc, inready, rdy); end
            tick(ic, d, fl, r);
            tests_run++;
            if (outclk !== m_outclk || out !== m_out || overflow !== m_ov || busy !== m_busy) begin
                tests_failed++;
                $display("FAIL rand_outputs cyc=%0d got outclk=%b out=%h ov=%b busy=%b exp outclk=%b out=%h ov=%b busy=%b",
                         cyc, outclk, out, overflow, busy, m_outclk, m_out, m_ov, m_busy);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_pair();
        test_back_to_back();
        tick(0, 12'h0, 0, 0);
        test_reset_mid();
        test_odd_flush();
        test_empty_flush();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
